// File: rtl/dac_serial_tx_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : dac_pkg
//  Description : Shared types and helpers for the serial DAC transmitter.
//                tx_state_t    - serializer state encoding
//                frame_cycles  - clk cycles needed to shift one stereo frame
//  Revision    : 1.0 - initial release
// ============================================================================
package dac_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LEFT  = 2'd1,
        RIGHT = 2'd2
    } tx_state_t;

    // Two words of `width` bits, each bit lasting one full bclk period
    // (2 * bclk_div clk cycles).
    function automatic int frame_cycles(input int width, input int bclk_div);
        return 2 * width * 2 * bclk_div;
    endfunction

endpackage
`default_nettype wire

// File: rtl/dac_serial_tx_if.sv
`default_nettype none
// ============================================================================
//  Module      : dac_serial_tx_if
//  Description : Sample input / serial output bundle of dac_serial_tx.
//                master : sample source (drives enable, left, right)
//                slave  : transmitter (drives sample_strobe, busy, bclk,
//                         lrclk, sdata)
//  Revision    : 1.0 - initial release
// ============================================================================
interface dac_serial_tx_if #(
    parameter int WIDTH = 4
);
    logic             enable;
    logic [WIDTH-1:0] left;
    logic [WIDTH-1:0] right;
    logic             sample_strobe;
    logic             busy;
    logic             bclk;
    logic             lrclk;
    logic             sdata;

    modport master (
        output enable, left, right,
        input  sample_strobe, busy, bclk, lrclk, sdata
    );

    modport slave (
        input  enable, left, right,
        output sample_strobe, busy, bclk, lrclk, sdata
    );
endinterface
`default_nettype wire

// File: rtl/dac_sample_timer.sv
`default_nettype none
// ============================================================================
//  Module      : dac_sample_timer
//  Description : Free-running sample-period counter 0..SAMPLE_TIME-1.
//                Held at 0 while disabled, so a tick fires on the very cycle
//                enable rises.
//  Ports       : clk      - system clock
//                reset    - asynchronous active-high reset
//                i_enable - run the counter
//                o_tick   - enabled cycle with counter at 0
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_sample_timer #(
    parameter int SAMPLE_TIME = 128
) (
    input  logic clk,
    input  logic reset,
    input  logic i_enable,
    output logic o_tick
);
    localparam int CNT_W = (SAMPLE_TIME > 1) ? $clog2(SAMPLE_TIME) : 1;
    localparam logic [CNT_W-1:0] c_last = CNT_W'(SAMPLE_TIME - 1);

    logic [CNT_W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_count <= '0;
        end else if (!i_enable) begin
            r_count <= '0;
        end else if (r_count == c_last) begin
            r_count <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    // Gated by reset so the strobe stays low while reset is asserted.
    assign o_tick = i_enable && (r_count == '0) && !reset;

endmodule
`default_nettype wire

// File: rtl/dac_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : dac_serial_tx
//  Description : Latches left/right samples on each sample tick and shifts
//                them MSB-first to a serial DAC, left word then right word.
//  Ports       : clk            - system clock
//                reset          - asynchronous active-high reset
//                bus.enable     - run the sample timer
//                bus.left/right - unsigned channel samples
//                bus.sample_strobe - inputs latched this cycle
//                bus.busy       - frame in flight
//                bus.bclk       - bit clock (DAC samples on rising edge)
//                bus.lrclk      - word select, 0 = left, 1 = right
//                bus.sdata      - serial data
//  Revision    : 1.0 - initial release
// ============================================================================
module dac_serial_tx
    import dac_pkg::*;
#(
    parameter int WIDTH       = 4,
    parameter int SAMPLE_TIME = 128,
    parameter int BCLK_DIV    = 2
) (
    input  logic            clk,
    input  logic            reset,
    dac_serial_tx_if.slave  bus
);
    localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int PH_W  = $clog2(2 * BCLK_DIV);

    localparam logic [IDX_W-1:0] c_idx_top = IDX_W'(WIDTH - 1);
    localparam logic [PH_W-1:0]  c_ph_last = PH_W'(2 * BCLK_DIV - 1);
    localparam logic [PH_W-1:0]  c_ph_high = PH_W'(BCLK_DIV);

    // A frame must finish before the next tick can restart the serializer.
    if (SAMPLE_TIME < frame_cycles(WIDTH, BCLK_DIV) + 1) begin : g_param_check
        $error("dac_serial_tx: SAMPLE_TIME too small for one frame");
    end

    logic             w_tick;
    tx_state_t        r_state, w_state_nxt;
    logic [IDX_W-1:0] r_idx, w_idx_nxt;
    logic [PH_W-1:0]  r_phase, w_phase_nxt;
    logic [WIDTH-1:0] r_left_sh, w_left_nxt;
    logic [WIDTH-1:0] r_right_sh, w_right_nxt;
    logic             r_busy, r_bclk, r_lrclk, r_sdata;
    logic             w_busy_nxt, w_bclk_nxt, w_lrclk_nxt, w_sdata_nxt;

    dac_sample_timer #(
        .SAMPLE_TIME (SAMPLE_TIME)
    ) u_timer (
        .clk      (clk),
        .reset    (reset),
        .i_enable (bus.enable),
        .o_tick   (w_tick)
    );

    // Next-state logic. Output pins are registered from the next-state
    // values so they are glitch-free and appear one cycle after the tick.
    always_comb begin
        w_state_nxt = r_state;
        w_idx_nxt   = r_idx;
        w_phase_nxt = r_phase;
        w_left_nxt  = r_left_sh;
        w_right_nxt = r_right_sh;

        if (w_tick) begin
            w_left_nxt  = bus.left;
            w_right_nxt = bus.right;
            w_state_nxt = LEFT;
            w_idx_nxt   = c_idx_top;
            w_phase_nxt = '0;
        end else if (r_state != IDLE) begin
            if (r_phase == c_ph_last) begin
                w_phase_nxt = '0;
                if (r_idx != '0) begin
                    w_idx_nxt = r_idx - 1'b1;
                end else if (r_state == LEFT) begin
                    w_state_nxt = RIGHT;
                    w_idx_nxt   = c_idx_top;
                end else begin
                    w_state_nxt = IDLE;
                end
            end else begin
                w_phase_nxt = r_phase + 1'b1;
            end
        end

        w_busy_nxt  = (w_state_nxt != IDLE);
        // bclk low for the first half of each bit so data settles before
        // the rising edge.
        w_bclk_nxt  = w_busy_nxt && (w_phase_nxt >= c_ph_high);
        w_lrclk_nxt = (w_state_nxt == RIGHT);
        case (w_state_nxt)
            LEFT:    w_sdata_nxt = w_left_nxt[w_idx_nxt];
            RIGHT:   w_sdata_nxt = w_right_nxt[w_idx_nxt];
            default: w_sdata_nxt = 1'b0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= IDLE;
            r_idx      <= '0;
            r_phase    <= '0;
            r_left_sh  <= '0;
            r_right_sh <= '0;
            r_busy     <= 1'b0;
            r_bclk     <= 1'b0;
            r_lrclk    <= 1'b0;
            r_sdata    <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_idx      <= w_idx_nxt;
            r_phase    <= w_phase_nxt;
            r_left_sh  <= w_left_nxt;
            r_right_sh <= w_right_nxt;
            r_busy     <= w_busy_nxt;
            r_bclk     <= w_bclk_nxt;
            r_lrclk    <= w_lrclk_nxt;
            r_sdata    <= w_sdata_nxt;
        end
    end

    assign bus.sample_strobe = w_tick;
    assign bus.busy          = r_busy;
    assign bus.bclk          = r_bclk;
    assign bus.lrclk         = r_lrclk;
    assign bus.sdata         = r_sdata;

endmodule
`default_nettype wire

// File: tb/tb_dac_serial_tx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dac_serial_tx
//  Description : Scoreboard bench for dac_serial_tx. The stimulus process
//                predicts each frame from the serial format rules and queues
//                the expected strobe and per-cycle pin values; a monitor on
//                the falling edge pops and compares them.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dac_serial_tx;
    import dac_pkg::*;

    localparam int WIDTH       = 4;
    localparam int SAMPLE_TIME = 40;
    localparam int BCLK_DIV    = 2;
    localparam int FRAME       = frame_cycles(WIDTH, BCLK_DIV);

    typedef struct {
        int         cyc;
        logic [2:0] v;      // {bclk, lrclk, sdata}
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;

    exp_t frame_q[$];
    int   strobe_q[$];
    int   cyc       = 0;
    int   n_checks  = 0;
    int   n_fail    = 0;
    int   mcount    = 0;
    int   last_tick = -1000;

    dac_serial_tx_if #(.WIDTH(WIDTH)) bus();

    dac_serial_tx #(
        .WIDTH       (WIDTH),
        .SAMPLE_TIME (SAMPLE_TIME),
        .BCLK_DIV    (BCLK_DIV)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got %b expected %b", name, cyc, act, exp);
        end
    endtask

    // Expected pins for the frame started by a tick in cycle t: one bclk
    // period per bit, MSB first, left word then right word.
    function automatic void push_frame(input int t, input logic [WIDTH-1:0] l,
                                       input logic [WIDTH-1:0] r);
        int k;
        k = t + 1;
        for (int w = 0; w < 2; w++) begin
            for (int b = WIDTH - 1; b >= 0; b--) begin
                for (int p = 0; p < 2 * BCLK_DIV; p++) begin
                    exp_t e;
                    e.cyc = k;
                    e.v   = {(p >= BCLK_DIV) ? 1'b1 : 1'b0,
                             (w == 1) ? 1'b1 : 1'b0,
                             (w == 1) ? r[b] : l[b]};
                    frame_q.push_back(e);
                    k++;
                end
            end
        end
    endfunction

    // Reference sample clock: one tick every SAMPLE_TIME enabled cycles,
    // restarting the period whenever enable is low.
    task automatic step_model();
        if (reset) begin
            mcount = 0;
            return;
        end
        if (bus.enable) begin
            if (mcount == 0) begin
                strobe_q.push_back(cyc);
                push_frame(cyc, bus.left, bus.right);
                last_tick = cyc;
            end
            mcount = (mcount + 1) % SAMPLE_TIME;
        end else begin
            mcount = 0;
        end
    endtask

    task automatic drive(input logic rst_v, input logic en,
                         input logic [WIDTH-1:0] l, input logic [WIDTH-1:0] r);
        @(posedge clk);
        #1;
        reset      = rst_v;
        bus.enable = en;
        bus.left   = l;
        bus.right  = r;
        step_model();
    endtask

    task automatic drive_rand(input logic en);
        drive(1'b0, en, WIDTH'($urandom), WIDTH'($urandom));
    endtask

    // Run enabled until the given number of cycles after the last tick.
    task automatic sync_to_frame_cycle(input int n, input string name);
        int guard;
        guard = 0;
        while ((cyc - last_tick) != n && guard < 2 * SAMPLE_TIME) begin
            drive_rand(1'b1);
            guard++;
        end
        check(name, {3'b0, (guard >= 2 * SAMPLE_TIME) ? 1'b1 : 1'b0}, 4'b0);
    endtask

    // Monitor
    always @(negedge clk) begin : mon
        logic       exp_s;
        logic [3:0] exp_o;
        exp_s = (strobe_q.size() > 0) && (strobe_q[0] == cyc);
        if (exp_s) void'(strobe_q.pop_front());
        check("strobe", {3'b0, bus.sample_strobe}, {3'b0, exp_s});
        exp_o = 4'b0;
        if (frame_q.size() > 0 && frame_q[0].cyc == cyc) begin
            exp_o = {1'b1, frame_q[0].v};
            void'(frame_q.pop_front());
        end
        check("pins{busy,bclk,lrclk,sdata}",
              {bus.busy, bus.bclk, bus.lrclk, bus.sdata}, exp_o);
    end

    initial begin
        int hi, lo;
        bus.enable = 1'b0;
        bus.left   = '0;
        bus.right  = '0;
        repeat (3) drive(1'b1, 1'b0, '0, '0);

        // Basic frame, then left changed two cycles after the strobe.
        drive(1'b0, 1'b1, 4'hA, 4'h5);
        for (int i = 1; i < SAMPLE_TIME; i++)
            drive(1'b0, 1'b1, (i >= 2) ? 4'h3 : 4'hA, 4'h5);
        repeat (SAMPLE_TIME) drive(1'b0, 1'b1, 4'h3, 4'h5);

        // Extremes
        repeat (2 * SAMPLE_TIME) drive(1'b0, 1'b1, 4'hF, 4'h0);
        repeat (2 * SAMPLE_TIME) drive_rand(1'b1);

        // Enable drop at cycle 10 of a frame, long pause, re-enable.
        sync_to_frame_cycle(9, "sync_enable_drop");
        repeat (200) drive_rand(1'b0);
        repeat (100) drive_rand(1'b1);

        // Random enable bursts; low periods outlast a frame.
        for (int blk = 0; blk < 12; blk++) begin
            hi = $urandom_range(1, 120);
            lo = $urandom_range(FRAME + 1, 80);
            repeat (hi) drive_rand(1'b1);
            repeat (lo) drive_rand(1'b0);
        end

        // Asynchronous reset at cycle 20 of a frame, between clock edges.
        drive_rand(1'b1);
        sync_to_frame_cycle(19, "sync_reset");
        @(posedge clk);
        #3;
        reset = 1'b1;
        frame_q.delete();
        strobe_q.delete();
        mcount = 0;
        #1;
        check("reset_pins", {bus.busy, bus.bclk, bus.lrclk, bus.sdata}, 4'b0);
        check("reset_strobe", {3'b0, bus.sample_strobe}, 4'b0);
        repeat (3) drive(1'b1, 1'b1, WIDTH'($urandom), WIDTH'($urandom));
        repeat (100) drive_rand(1'b1);

        // Drain and confirm every expected event was seen.
        repeat (FRAME + 8) drive_rand(1'b0);
        check("queues_drained",
              {3'b0, (frame_q.size() + strobe_q.size() != 0) ? 1'b1 : 1'b0}, 4'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
